// File: rtl/alu_nibble_seq_if.sv
// Request/result bundle between microcode decode (master) and the
// nibble-serial ALU sequencer (slave).
interface alu_nibble_seq_if;
  logic       start;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       cancel;
  logic       ready;
  logic       done;
  logic [7:0] result;
  logic       flag_z;
  logic       flag_n;
  logic       flag_h;
  logic       flag_c;

  modport master (
    output start, op, a, b, cin, cancel,
    input  ready, done, result, flag_z, flag_n, flag_h, flag_c
  );

  modport slave (
    input  start, op, a, b, cin, cancel,
    output ready, done, result, flag_z, flag_n, flag_h, flag_c
  );
endinterface

// File: rtl/alu_nibble_seq.sv
// Nibble-serial 8-bit ALU sequencer: low nibble pass, then high nibble pass
// with the half-carry chained between them. Fixed two-cycle latency for all
// ops; result and flags only change on the done pulse.
//
//   state  | meaning
//   IDLE   | ready for a request
//   LO     | computing low nibble, capturing half-carry
//   HI     | computing high nibble, registering result/flags, pulsing done
module alu_nibble_seq #(
  parameter bit ALLOW_B2B = 1'b0
) (
  input  logic            clk,
  input  logic            nreset,
  alu_nibble_seq_if.slave bus
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_ADC = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_SBC = 3'd3;
  localparam logic [2:0] OP_AND = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_CP  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] op_q;
  logic [7:0] a_q, b_q;
  logic       cin_q;
  logic [3:0] lo_q;
  logic       hc_q;
  logic [7:0] result_q;
  logic       z_q, n_q, h_q, c_q;
  logic       done_q;

  logic       accept;
  logic       lo_we;
  logic       fin;
  logic       ready;
  logic       is_add, is_sub;
  logic       lo_ci;
  logic [4:0] lo_sum, hi_sum;
  logic [7:0] diff;

  // One 4-bit pass. For subtract-type ops the B nibble is inverted and ci is
  // the "no borrow" carry, so the raw carry out chains directly into the
  // next pass.
  function automatic logic [4:0] nib_op(input logic [2:0] op,
                                        input logic [3:0] x,
                                        input logic [3:0] y,
                                        input logic       ci);
    logic [4:0] s;
    s = 5'd0;
    case (op)
      OP_ADD, OP_ADC:        s = {1'b0, x} + {1'b0, y}  + {4'd0, ci};
      OP_SUB, OP_SBC, OP_CP: s = {1'b0, x} + {1'b0, ~y} + {4'd0, ci};
      OP_AND:                s = {1'b0, x & y};
      OP_XOR:                s = {1'b0, x ^ y};
      default:               s = {1'b0, x | y};
    endcase
    return s;
  endfunction

  // Operation class decode and both nibble passes from the latched request.
  always_comb begin
    is_add = (op_q == OP_ADD) || (op_q == OP_ADC);
    is_sub = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CP);
    lo_ci  = 1'b0;
    case (op_q)
      OP_ADC:        lo_ci = cin_q;
      OP_SBC:        lo_ci = ~cin_q;
      OP_SUB, OP_CP: lo_ci = 1'b1;
      default:       lo_ci = 1'b0;
    endcase
    lo_sum = nib_op(op_q, a_q[3:0], b_q[3:0], lo_ci);
    hi_sum = nib_op(op_q, a_q[7:4], b_q[7:4], hc_q);
    diff   = {hi_sum[3:0], lo_q};
  end

  // Next-state and control decode; cancel beats a back-to-back start in HI.
  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    accept  = 1'b0;
    lo_we   = 1'b0;
    fin     = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (bus.start) begin
          accept  = 1'b1;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (bus.cancel) begin
          state_d = S_IDLE;
        end else begin
          lo_we   = 1'b1;
          state_d = S_HI;
        end
      end
      S_HI: begin
        ready = ALLOW_B2B;
        if (bus.cancel) begin
          state_d = S_IDLE;
        end else begin
          fin = 1'b1;
          if (ALLOW_B2B && bus.start) begin
            accept  = 1'b1;
            state_d = S_LO;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Request capture at acceptance and low-pass result/half-carry.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      op_q  <= 3'd0;
      a_q   <= 8'd0;
      b_q   <= 8'd0;
      cin_q <= 1'b0;
      lo_q  <= 4'd0;
      hc_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= bus.op;
        a_q   <= bus.a;
        b_q   <= bus.b;
        cin_q <= bus.cin;
      end
      if (lo_we) begin
        lo_q <= lo_sum[3:0];
        hc_q <= lo_sum[4];
      end
    end
  end

  // Result and flags update only when the high pass completes.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      result_q <= 8'd0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      h_q      <= 1'b0;
      c_q      <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= fin;
      if (fin) begin
        result_q <= (op_q == OP_CP) ? a_q : diff;
        z_q      <= (diff == 8'd0);
        n_q      <= is_sub;
        h_q      <= is_add ? hc_q : (is_sub ? ~hc_q : (op_q == OP_AND));
        c_q      <= is_add ? hi_sum[4] : (is_sub ? ~hi_sum[4] : 1'b0);
      end
    end
  end

  assign bus.ready  = ready;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.flag_z = z_q;
  assign bus.flag_n = n_q;
  assign bus.flag_h = h_q;
  assign bus.flag_c = c_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq: one instance without and one with
// back-to-back acceptance, sharing clock and reset.
module tb_alu_nibble_seq;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  alu_nibble_seq_if if0();
  alu_nibble_seq_if if1();

  alu_nibble_seq #(.ALLOW_B2B(1'b0)) u_dut0 (.clk(clk), .nreset(nreset), .bus(if0.slave));
  alu_nibble_seq #(.ALLOW_B2B(1'b1)) u_dut1 (.clk(clk), .nreset(nreset), .bus(if1.slave));

  logic [3:0] fl0, fl1;
  assign fl0 = {if0.flag_z, if0.flag_n, if0.flag_h, if0.flag_c};
  assign fl1 = {if1.flag_z, if1.flag_n, if1.flag_h, if1.flag_c};

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic [3:0] fl;   // {Z,N,H,C}
  } vec_t;

  task automatic test_reset();
    nreset = 1'b0;
    #12;
    checks++; if (if0.ready !== 1'b1) begin failures++; $display("FAIL reset_ready0 got=%b exp=1", if0.ready); end
    checks++; if (if0.done !== 1'b0) begin failures++; $display("FAIL reset_done0 got=%b exp=0", if0.done); end
    checks++; if (if0.result !== 8'h00 || fl0 !== 4'b0000) begin failures++; $display("FAIL reset_out0 got=%h/%b exp=00/0000", if0.result, fl0); end
    checks++; if (if1.ready !== 1'b1 || if1.done !== 1'b0 || if1.result !== 8'h00 || fl1 !== 4'b0000) begin
      failures++; $display("FAIL reset_out1 got rdy=%b done=%b res=%h fl=%b exp 1/0/00/0000", if1.ready, if1.done, if1.result, fl1);
    end
    @(negedge clk); nreset = 1'b1;
  endtask

  task automatic test_arith();
    vec_t v[12];
    v[0]  = '{3'd0, 8'h3A, 8'hC6, 1'b0, 8'h00, 4'b1011}; // ADD
    v[1]  = '{3'd2, 8'h00, 8'h01, 1'b0, 8'hFF, 4'b0111}; // SUB
    v[2]  = '{3'd3, 8'h10, 8'h0F, 1'b1, 8'h00, 4'b1110}; // SBC
    v[3]  = '{3'd1, 8'h0F, 8'h00, 1'b1, 8'h10, 4'b0010}; // ADC
    v[4]  = '{3'd7, 8'h42, 8'h42, 1'b0, 8'h42, 4'b1100}; // CP equal
    v[5]  = '{3'd4, 8'hF0, 8'h0F, 1'b0, 8'h00, 4'b1010}; // AND
    v[6]  = '{3'd5, 8'hFF, 8'hFF, 1'b0, 8'h00, 4'b1000}; // XOR
    v[7]  = '{3'd6, 8'h50, 8'h0A, 1'b1, 8'h5A, 4'b0000}; // OR
    v[8]  = '{3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1011}; // ADD wrap
    v[9]  = '{3'd2, 8'h05, 8'h03, 1'b1, 8'h02, 4'b0100}; // SUB ignores cin
    v[10] = '{3'd0, 8'h01, 8'h01, 1'b1, 8'h02, 4'b0000}; // ADD ignores cin
    v[11] = '{3'd7, 8'h10, 8'h20, 1'b0, 8'h10, 4'b0101}; // CP borrow
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if0.op = v[i].op; if0.a = v[i].a; if0.b = v[i].b; if0.cin = v[i].cin; if0.start = 1'b1;
      @(posedge clk); #1; if0.start = 1'b0;
      checks++; if (if0.ready !== 1'b0 || if0.done !== 1'b0) begin failures++; $display("FAIL arith_accept[%0d] got rdy=%b done=%b exp 0/0", i, if0.ready, if0.done); end
      @(posedge clk); #1;
      checks++; if (if0.ready !== 1'b0 || if0.done !== 1'b0) begin failures++; $display("FAIL arith_pass1[%0d] got rdy=%b done=%b exp 0/0", i, if0.ready, if0.done); end
      @(posedge clk); #1;
      checks++; if (if0.done !== 1'b1) begin failures++; $display("FAIL arith_done[%0d] got=%b exp=1", i, if0.done); end
      checks++; if (if0.result !== v[i].res) begin failures++; $display("FAIL arith_result[%0d] got=%h exp=%h", i, if0.result, v[i].res); end
      checks++; if (fl0 !== v[i].fl) begin failures++; $display("FAIL arith_flags[%0d] got=%b exp=%b", i, fl0, v[i].fl); end
      checks++; if (if0.ready !== 1'b1) begin failures++; $display("FAIL arith_ready[%0d] got=%b exp=1", i, if0.ready); end
      @(posedge clk); #1;
      checks++; if (if0.done !== 1'b0 || if0.result !== v[i].res) begin failures++; $display("FAIL arith_hold[%0d] got done=%b res=%h exp 0/%h", i, if0.done, if0.result, v[i].res); end
    end
  endtask

  task automatic test_busy_ignored();
    @(negedge clk);
    if0.op = 3'd0; if0.a = 8'h12; if0.b = 8'h34; if0.cin = 1'b0; if0.start = 1'b1;
    @(posedge clk); #1;
    if0.op = 3'd2; if0.a = 8'hFF; if0.b = 8'hFF; if0.cin = 1'b1;
    @(posedge clk); #1;
    checks++; if (if0.done !== 1'b0) begin failures++; $display("FAIL busy_early_done got=%b exp=0", if0.done); end
    @(posedge clk); #1; if0.start = 1'b0;
    checks++; if (if0.done !== 1'b1 || if0.result !== 8'h46 || fl0 !== 4'b0000) begin
      failures++; $display("FAIL busy_result got done=%b res=%h fl=%b exp 1/46/0000", if0.done, if0.result, fl0);
    end
    @(posedge clk); #1;
    checks++; if (if0.ready !== 1'b1 || if0.done !== 1'b0) begin failures++; $display("FAIL busy_not_queued got rdy=%b done=%b exp 1/0", if0.ready, if0.done); end
    @(posedge clk); #1;
    checks++; if (if0.done !== 1'b0 || if0.result !== 8'h46) begin failures++; $display("FAIL busy_hold got done=%b res=%h exp 0/46", if0.done, if0.result); end
  endtask

  task automatic test_cancel_lo();
    @(negedge clk);
    if0.op = 3'd0; if0.a = 8'h3A; if0.b = 8'hC6; if0.cin = 1'b0; if0.start = 1'b1;
    @(posedge clk); #1; if0.start = 1'b0; if0.cancel = 1'b1;
    @(posedge clk); #1; if0.cancel = 1'b0;
    checks++; if (if0.ready !== 1'b1 || if0.done !== 1'b0) begin failures++; $display("FAIL cancel_lo_idle got rdy=%b done=%b exp 1/0", if0.ready, if0.done); end
    @(posedge clk); #1;
    checks++; if (if0.done !== 1'b0 || if0.result !== 8'h46 || fl0 !== 4'b0000) begin
      failures++; $display("FAIL cancel_lo_retain got done=%b res=%h fl=%b exp 0/46/0000", if0.done, if0.result, fl0);
    end
    @(negedge clk);
    if0.op = 3'd2; if0.a = 8'h00; if0.b = 8'h01; if0.cin = 1'b0; if0.start = 1'b1;
    @(posedge clk); #1; if0.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (if0.done !== 1'b1 || if0.result !== 8'hFF || fl0 !== 4'b0111) begin
      failures++; $display("FAIL cancel_lo_next got done=%b res=%h fl=%b exp 1/FF/0111", if0.done, if0.result, fl0);
    end
  endtask

  task automatic test_cancel_with_start();
    @(negedge clk);
    if0.op = 3'd5; if0.a = 8'h0F; if0.b = 8'h3C; if0.cin = 1'b0; if0.start = 1'b1; if0.cancel = 1'b1;
    @(posedge clk); #1; if0.start = 1'b0; if0.cancel = 1'b0;
    checks++; if (if0.ready !== 1'b0) begin failures++; $display("FAIL start_wins_accept got rdy=%b exp=0", if0.ready); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (if0.done !== 1'b1 || if0.result !== 8'h33 || fl0 !== 4'b0000) begin
      failures++; $display("FAIL start_wins_result got done=%b res=%h fl=%b exp 1/33/0000", if0.done, if0.result, fl0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    if1.op = 3'd0; if1.a = 8'h3A; if1.b = 8'hC6; if1.cin = 1'b0; if1.start = 1'b1;
    @(posedge clk); #1;
    if1.op = 3'd6; if1.a = 8'h50; if1.b = 8'h0A; if1.cin = 1'b0;
    checks++; if (if1.ready !== 1'b0) begin failures++; $display("FAIL b2b_lo_ready got=%b exp=0", if1.ready); end
    @(posedge clk); #1;
    checks++; if (if1.ready !== 1'b1 || if1.done !== 1'b0) begin failures++; $display("FAIL b2b_hi_ready got rdy=%b done=%b exp 1/0", if1.ready, if1.done); end
    @(posedge clk); #1; if1.start = 1'b0;
    checks++; if (if1.done !== 1'b1 || if1.result !== 8'h00 || fl1 !== 4'b1011) begin
      failures++; $display("FAIL b2b_first got done=%b res=%h fl=%b exp 1/00/1011", if1.done, if1.result, fl1);
    end
    checks++; if (if1.ready !== 1'b0) begin failures++; $display("FAIL b2b_second_accept got rdy=%b exp=0", if1.ready); end
    @(posedge clk); #1;
    checks++; if (if1.done !== 1'b0) begin failures++; $display("FAIL b2b_gap got=%b exp=0", if1.done); end
    @(posedge clk); #1;
    checks++; if (if1.done !== 1'b1 || if1.result !== 8'h5A || fl1 !== 4'b0000) begin
      failures++; $display("FAIL b2b_second got done=%b res=%h fl=%b exp 1/5A/0000", if1.done, if1.result, fl1);
    end
    @(posedge clk); #1;
    checks++; if (if1.done !== 1'b0 || if1.ready !== 1'b1) begin failures++; $display("FAIL b2b_end got done=%b rdy=%b exp 0/1", if1.done, if1.ready); end
  endtask

  task automatic test_cancel_hi_b2b();
    @(negedge clk);
    if1.op = 3'd0; if1.a = 8'h12; if1.b = 8'h34; if1.cin = 1'b0; if1.start = 1'b1;
    @(posedge clk); #1; if1.start = 1'b0;
    @(posedge clk); #1;
    if1.op = 3'd4; if1.a = 8'hFF; if1.b = 8'hFF; if1.start = 1'b1; if1.cancel = 1'b1;
    @(posedge clk); #1; if1.start = 1'b0; if1.cancel = 1'b0;
    checks++; if (if1.done !== 1'b0 || if1.ready !== 1'b1) begin failures++; $display("FAIL cancel_hi got done=%b rdy=%b exp 0/1", if1.done, if1.ready); end
    @(posedge clk); #1;
    checks++; if (if1.done !== 1'b0 || if1.result !== 8'h5A || fl1 !== 4'b0000) begin
      failures++; $display("FAIL cancel_hi_retain got done=%b res=%h fl=%b exp 0/5A/0000", if1.done, if1.result, fl1);
    end
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    if0.op = 3'd0; if0.a = 8'h3A; if0.b = 8'hC6; if0.cin = 1'b0; if0.start = 1'b1;
    @(posedge clk); #1; if0.start = 1'b0;
    @(posedge clk); #2; nreset = 1'b0;
    #1;
    checks++; if (if0.ready !== 1'b1 || if0.done !== 1'b0 || if0.result !== 8'h00 || fl0 !== 4'b0000) begin
      failures++; $display("FAIL reset_mid got rdy=%b done=%b res=%h fl=%b exp 1/0/00/0000", if0.ready, if0.done, if0.result, fl0);
    end
    @(negedge clk); nreset = 1'b1;
    @(posedge clk); #1;
    checks++; if (if0.done !== 1'b0 || if0.ready !== 1'b1) begin failures++; $display("FAIL reset_mid_after got done=%b rdy=%b exp 0/1", if0.done, if0.ready); end
    @(posedge clk); #1;
    checks++; if (if0.done !== 1'b0 || if0.result !== 8'h00) begin failures++; $display("FAIL reset_mid_nodone got done=%b res=%h exp 0/00", if0.done, if0.result); end
  endtask

  initial begin
    if0.start = 1'b0; if0.op = 3'd0; if0.a = 8'h00; if0.b = 8'h00; if0.cin = 1'b0; if0.cancel = 1'b0;
    if1.start = 1'b0; if1.op = 3'd0; if1.a = 8'h00; if1.b = 8'h00; if1.cin = 1'b0; if1.cancel = 1'b0;
    test_reset();
    test_arith();
    test_busy_ignored();
    test_cancel_lo();
    test_cancel_with_start();
    test_back_to_back();
    test_cancel_hi_b2b();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
